// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Inhibits the bus, requests to send, then shifts the frame on device clocks.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 200,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          fall;
    logic [31:0]   cnt;
    logic [3:0]    nedge;
    logic [7:0]    data_q;
    logic          par_q;
    logic          data_oe_q;
    logic [1:0]    code_q, code_n;
    logic          timed;
    logic          accept;

    assign tx_ready   = (state == IDLE);
    assign accept     = tx_valid & tx_ready;
    assign timed      = (state == SEND) || (state == ACK)
                     || (state == WAIT_IDLE);
    assign ps2clk_oe  = (state == INHIBIT) || (state == START);
    assign ps2data_oe = (state == START)
                     || ((state == SEND) && data_oe_q);
    assign err_code   = err ? code_n : code_q;

    // Synchronize both pads, debounce them and strobe filtered clock falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            filt  <= 2'b11;
            fcnt  <= '{default: '0};
            fall  <= 1'b0;
        end else begin
            sync1 <= {ps2data_i, ps2clk_i};
            sync2 <= sync1;
            fall  <= filt[0] & ~sync2[0]
                   & (fcnt[0] == FW'(FILTER_LEN - 1));
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    fcnt[i] <= '0;
                    filt[i] <= sync2[i];
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and completion pulses; a timeout overrides the normal flow.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        err     = 1'b0;
        code_n  = code_q;
        unique case (state)
            IDLE: begin
                if (accept) state_n = INHIBIT;
            end
            INHIBIT: begin
                if (cnt == 32'(INHIBIT_CYCLES - 1)) state_n = START;
            end
            START: begin
                if (cnt == 32'(START_CYCLES - 1)) state_n = SEND;
            end
            SEND: begin
                if (fall && nedge == 4'd9) state_n = ACK;
            end
            ACK: begin
                if (fall) begin
                    if (filt[1]) begin
                        err     = 1'b1;
                        code_n  = 2'b10;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (filt[0] && filt[1]) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timed && !fall && !done
            && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            err     = 1'b1;
            code_n  = 2'b01;
            state_n = IDLE;
        end
    end

    // Phase counter, latched byte, bit counter and registered data drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            nedge     <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            data_oe_q <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            if (state == IDLE || state_n != state || (timed && fall))
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
            if (accept) begin
                data_q <= tx_data;
                par_q  <= ~^tx_data;
            end
            if (err) code_q <= code_n;
            if (state == START) begin
                data_oe_q <= 1'b1;
                nedge     <= '0;
            end else if (state == SEND && fall) begin
                nedge <= nedge + 4'd1;
                if (nedge < 4'd8)
                    data_oe_q <= ~data_q[nedge[2:0]];
                else if (nedge == 4'd8)
                    data_oe_q <= ~par_q;
                else
                    data_oe_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles PS2Clk is held low before a request (100 us at 100 MHz).
REQ-002 Parameter START_CYCLES, default 200, clk cycles PS2Data is held low before PS2Clk is released.
REQ-003 Parameter TIMEOUT_CYCLES, default 1500000, maximum clk cycles allowed between consecutive device PS2Clk falling edges, and from clock release to the first edge.
REQ-004 Parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a PS/2 line level.
REQ-005 clk  in  1  system clock, rising-edge active.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tx_data  in  8  byte to send to the device (command or argument).
REQ-008 tx_valid  in  1  request; accepted only when tx_valid and tx_ready are both 1.
REQ-009 tx_ready  out  1  1 = idle and able to accept a byte.
REQ-010 ps2clk_i / ps2data_i  in  1 each  PS2Clk / PS2Data pad levels (asynchronous).
REQ-011 ps2clk_oe / ps2data_oe  out  1 each  1 = drive the pad low; 0 = release it (pulled up).
REQ-012 done  out  1  one-cycle pulse: transfer finished and acknowledged.
REQ-013 err  out  1  one-cycle pulse: transfer aborted; err_code is valid in the same cycle.
REQ-014 err_code  out  2  01 = timeout, 10 = no ACK (ACK bit sampled 1); holds its value until the next err.

Function
REQ-015 Both pad inputs pass through a 2-flop synchronizer, then a FILTER_LEN stable-sample filter.
REQ-016 A PS2Clk falling edge is a filtered 1->0 transition, reported as a one-cycle strobe.
REQ-017 States: IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-018 IDLE: tx_ready=1, both oe=0; on accept, latch tx_data, compute odd parity (~^data), go to INHIBIT.
REQ-019 INHIBIT: ps2clk_oe=1 for INHIBIT_CYCLES, then go to START.
REQ-020 START: ps2data_oe=1 and ps2clk_oe=1 for START_CYCLES, then release ps2clk_oe and go to SEND with edge count 0.
REQ-021 SEND: on each falling edge, increment the edge count n.
REQ-022 SEND, n=1..8: after edge n, ps2data_oe = ~data[n-1] (LSB first).
REQ-023 SEND, n=9: after edge 9, ps2data_oe = ~parity.
REQ-024 SEND, n=10: after edge 10, ps2data_oe=0 (stop bit), then go to ACK.
REQ-025 The data output changes only in the cycle after a falling-edge strobe and is stable otherwise.
REQ-026 ACK: on the next falling edge, sample filtered ps2data_i; 0 = ACK, go to WAIT_IDLE; 1 = err with code 10, go to IDLE.
REQ-027 WAIT_IDLE: when filtered PS2Clk and PS2Data are both 1, pulse done and go to IDLE.
REQ-028 A timeout counter resets on every falling edge and on entry to SEND.
REQ-029 Timeout in SEND, ACK or WAIT_IDLE: when the counter reaches TIMEOUT_CYCLES, release both oe, pulse err with code 01, go to IDLE.
REQ-030 tx_valid while tx_ready=0 is ignored (no queuing).
REQ-031 done and err are never asserted in the same cycle.
REQ-032 tx_ready returns to 1 in the cycle after a done or err pulse.
REQ-033 Falling edges in IDLE, INHIBIT or START are ignored.

Reset
REQ-034 rst_n=0 immediately forces: state IDLE, ps2clk_oe=0, ps2data_oe=0, done=0, err=0, err_code=00, tx_ready=1.
REQ-035 All counters, the shift data and the synchronizer/filter flops reset to 0 (filter outputs to 1, lines idle).
REQ-036 Reset during a transfer releases both lines within the same cycle; no done or err pulse follows.

Verification
V1: send 0xED; device model clocks 11 edges and ACKs -> bits after edges 1-8 = 1,0,1,1,0,1,1,1; parity=1; stop=1; one done pulse; no err.
V2: send 0x01 -> parity bit 0; send 0xFF -> parity bit 1; send 0x00 -> parity bit 1; each ends in done.
V3: device leaves data high at edge 11 -> err pulse, err_code=10; tx_ready=1 the next cycle.
V4: device stops clocking after edge 4 -> err at TIMEOUT_CYCLES after edge 4, err_code=01; both oe=0.
V5: tx_valid pulsed with 0x55 during a 0xED transfer -> ignored; only 0xED bits appear on the line.
V6: rst_n low mid-SEND (after edge 5) -> both oe=0 at once, tx_ready=1; no done/err; next request completes normally.
V7: single-cycle glitch on ps2clk_i (shorter than FILTER_LEN) -> no edge counted; bit stream unchanged.
